step_motor_multi_axis: RTL and testbench



---
 rtl/step_motor_pkg.sv | 52 +++++
 rtl/step_motor_axis.sv | 229 ++++++++++++++++++++++
 rtl/step_motor_multi_axis.sv | 82 ++++++++
 tb/tb_step_motor_multi_axis.sv | 138 +++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// Shared definitions for the multi-axis stepper controller: register map,
// ctrl/status bit positions, coil phase table, move FSM states.
package step_motor_pkg;

   localparam logic [2:0] REG_PERIOD   = 3'd0;
   localparam logic [2:0] REG_DUTY_A   = 3'd1;
   localparam logic [2:0] REG_DUTY_B   = 3'd2;
   localparam logic [2:0] REG_INTERVAL = 3'd3;
   localparam logic [2:0] REG_COUNT    = 3'd4;
   localparam logic [2:0] REG_CTRL     = 3'd5;
   localparam logic [2:0] REG_POS      = 3'd6;
   localparam logic [2:0] REG_STATUS   = 3'd7;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_DIR  = 1;
   localparam int CTRL_HALF = 2;
   localparam int CTRL_IRQ  = 3;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;

   // Phase table entry bits: {A+, A-, B+, B-}
   localparam int PH_AP = 3;
   localparam int PH_AN = 2;
   localparam int PH_BP = 1;
   localparam int PH_BN = 0;

   // Index 7 is the leftmost element, index 0 the rightmost.
   localparam logic [7:0][3:0] PHASE_TBL = {
      4'b1001,   // 7 A+ B-
      4'b0001,   // 6 B-
      4'b0101,   // 5 A- B-
      4'b0100,   // 4 A-
      4'b0110,   // 3 A- B+
      4'b0010,   // 2 B+
      4'b1010,   // 1 A+ B+
      4'b1000    // 0 A+
   };

   typedef enum logic {S_IDLE, S_RUN} move_state_e;

   // Merge write data into an existing word under byte-lane enables.
   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/step_motor_axis.sv
// One stepper axis: register file, step-rate timer, move FSM, phase/position
// tracking, two-channel PWM chopper and active-low coil/bridge outputs.
module step_motor_axis
   import step_motor_pkg::*;
#(
   parameter int PWM_W  = 16,
   parameter int RATE_W = 24,
   parameter int POS_W  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  reg_addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rd_word,
   output logic        irq,
   output logic        coil_ax,
   output logic        coil_ay,
   output logic        coil_bx,
   output logic        coil_by,
   output logic        bridge_ae,
   output logic        bridge_be
);

   // Programmed (host-visible) registers
   logic [PWM_W-1:0]  period_q, period_d;
   logic [PWM_W-1:0]  duty_a_q, duty_a_d;
   logic [PWM_W-1:0]  duty_b_q, duty_b_d;
   logic [RATE_W-1:0] interval_q, interval_d;
   logic [31:0]       count_q, count_d;
   logic [3:0]        ctrl_q, ctrl_d;
   // Working copies, reloaded only on timer / PWM cycle boundaries
   logic [PWM_W-1:0]  per_act_q, per_act_d;
   logic [PWM_W-1:0]  da_act_q, da_act_d;
   logic [PWM_W-1:0]  db_act_q, db_act_d;
   logic [RATE_W-1:0] int_act_q, int_act_d;
   // Motion state
   move_state_e              state_q, state_d;
   logic [RATE_W-1:0]        timer_q, timer_d;
   logic [31:0]              remaining_q, remaining_d;
   logic [2:0]               phase_q, phase_d;
   logic signed [POS_W-1:0]  position_q, position_d;
   logic                     done_q, done_d;
   logic [PWM_W-1:0]         pwm_cnt_q, pwm_cnt_d;

   logic [31:0]       wmerge;
   logic [RATE_W-1:0] lim;
   logic              tc, start, kill, step, busy;
   logic              pwm_a, pwm_b;
   logic [3:0]        ph;

   assign busy = (state_q == S_RUN);

   // Register readback; current values, so a same-cycle write is not seen
   always_comb begin
      rd_word = 32'd0;
      case (reg_addr)
         REG_PERIOD:   rd_word = 32'(period_q);
         REG_DUTY_A:   rd_word = 32'(duty_a_q);
         REG_DUTY_B:   rd_word = 32'(duty_b_q);
         REG_INTERVAL: rd_word = 32'(interval_q);
         REG_COUNT:    rd_word = count_q;
         REG_CTRL:     rd_word = 32'(ctrl_q);
         REG_POS:      rd_word = 32'(position_q);
         REG_STATUS:   rd_word = {30'd0, done_q, busy};
         default:      rd_word = 32'd0;
      endcase
   end

   assign wmerge = be_merge(rd_word, wdata, byteen);

   // Next-state logic: register writes, move FSM, stepping and PWM counter
   always_comb begin
      period_d    = period_q;
      duty_a_d    = duty_a_q;
      duty_b_d    = duty_b_q;
      interval_d  = interval_q;
      count_d     = count_q;
      ctrl_d      = ctrl_q;
      per_act_d   = per_act_q;
      da_act_d    = da_act_q;
      db_act_d    = db_act_q;
      int_act_d   = int_act_q;
      state_d     = state_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      position_d  = position_q;
      done_d      = done_q;
      pwm_cnt_d   = pwm_cnt_q;
      start       = 1'b0;
      kill        = 1'b0;
      step        = 1'b0;

      lim = (int_act_q < RATE_W'(2)) ? RATE_W'(2) : int_act_q;
      tc  = (timer_q == lim - RATE_W'(1));

      if (wr_en) begin
         case (reg_addr)
            REG_PERIOD:   period_d   = wmerge[PWM_W-1:0];
            REG_DUTY_A:   duty_a_d   = wmerge[PWM_W-1:0];
            REG_DUTY_B:   duty_b_d   = wmerge[PWM_W-1:0];
            REG_INTERVAL: interval_d = wmerge[RATE_W-1:0];
            REG_COUNT: begin
               count_d = wmerge;
               start   = (wmerge != 32'd0) && ctrl_q[CTRL_EN];
            end
            REG_CTRL: begin
               ctrl_d = wdata[3:0];
               kill   = !wdata[CTRL_EN];
            end
            REG_STATUS: begin
               kill = wdata[ST_BUSY];
               if (wdata[ST_DONE]) done_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (state_q == S_RUN) begin
         if (kill) begin
            // Abort / disable: stop now, hold phase and position, no done
            state_d = S_IDLE;
         end else begin
            timer_d = tc ? RATE_W'(0) : timer_q + RATE_W'(1);
            if (tc) begin
               step        = 1'b1;
               int_act_d   = interval_q;
               remaining_d = remaining_q - 32'd1;
               if (remaining_q == 32'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            // Reload on a new count; the timer keeps running
            if (start) begin
               remaining_d = wmerge;
               state_d     = S_RUN;
               if (tc && remaining_q == 32'd1) done_d = done_q;
            end
         end
      end else begin
         int_act_d = interval_q;
         if (start) begin
            state_d     = S_RUN;
            remaining_d = wmerge;
            timer_d     = RATE_W'(0);
            done_d      = 1'b0;
         end
      end

      if (step) begin
         if (ctrl_q[CTRL_DIR]) begin
            phase_d    = phase_q + (ctrl_q[CTRL_HALF] ? 3'd1 : 3'd2);
            position_d = position_q + POS_W'(1);
         end else begin
            phase_d    = phase_q - (ctrl_q[CTRL_HALF] ? 3'd1 : 3'd2);
            position_d = position_q - POS_W'(1);
         end
      end

      // PWM counter; new period/duty values are adopted only at wrap
      if (per_act_q == '0 || pwm_cnt_q >= per_act_q - PWM_W'(1)) begin
         pwm_cnt_d = '0;
         per_act_d = period_q;
         da_act_d  = duty_a_q;
         db_act_d  = duty_b_q;
      end else begin
         pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_q    <= '0;
         duty_a_q    <= '0;
         duty_b_q    <= '0;
         interval_q  <= '0;
         count_q     <= '0;
         ctrl_q      <= '0;
         per_act_q   <= '0;
         da_act_q    <= '0;
         db_act_q    <= '0;
         int_act_q   <= '0;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         remaining_q <= '0;
         phase_q     <= '0;
         position_q  <= '0;
         done_q      <= 1'b0;
         pwm_cnt_q   <= '0;
      end else begin
         period_q    <= period_d;
         duty_a_q    <= duty_a_d;
         duty_b_q    <= duty_b_d;
         interval_q  <= interval_d;
         count_q     <= count_d;
         ctrl_q      <= ctrl_d;
         per_act_q   <= per_act_d;
         da_act_q    <= da_act_d;
         db_act_q    <= db_act_d;
         int_act_q   <= int_act_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
         position_q  <= position_d;
         done_q      <= done_d;
         pwm_cnt_q   <= pwm_cnt_d;
      end
   end

   // Coil drives: active-low, gated by phase polarity, chopper and enable
   always_comb begin
      ph        = PHASE_TBL[phase_q];
      pwm_a     = (per_act_q != '0) && (pwm_cnt_q < da_act_q);
      pwm_b     = (per_act_q != '0) && (pwm_cnt_q < db_act_q);
      coil_ax   = !(ph[PH_AP] && pwm_a && ctrl_q[CTRL_EN]);
      coil_ay   = !(ph[PH_AN] && pwm_a && ctrl_q[CTRL_EN]);
      coil_bx   = !(ph[PH_BP] && pwm_b && ctrl_q[CTRL_EN]);
      coil_by   = !(ph[PH_BN] && pwm_b && ctrl_q[CTRL_EN]);
      bridge_ae = !ctrl_q[CTRL_EN];
      bridge_be = !ctrl_q[CTRL_EN];
      irq       = done_q && ctrl_q[CTRL_IRQ];
   end

endmodule

// File: rtl/step_motor_multi_axis.sv
// Avalon-MM front end for NUM_AXES stepper axes: address decode, registered
// read mux and interrupt OR. Per-axis logic lives in step_motor_axis.
module step_motor_multi_axis
   import step_motor_pkg::*;
#(
   parameter int NUM_AXES = 2,
   parameter int PWM_W    = 16,
   parameter int RATE_W   = 24,
   parameter int POS_W    = 32,
   localparam int ADDR_W  = 3 + $clog2(NUM_AXES)
) (
   input  logic                csi_MCLK_clk,
   input  logic                rsi_MRST_reset_n,
   input  logic [ADDR_W-1:0]   avs_ctrl_address,
   input  logic [31:0]         avs_ctrl_writedata,
   output logic [31:0]         avs_ctrl_readdata,
   input  logic [3:0]          avs_ctrl_byteenable,
   input  logic                avs_ctrl_write,
   input  logic                avs_ctrl_read,
   output logic                avs_ctrl_waitrequest,
   output logic                ins_irq_irq,
   output logic [NUM_AXES-1:0] AX,
   output logic [NUM_AXES-1:0] AY,
   output logic [NUM_AXES-1:0] BX,
   output logic [NUM_AXES-1:0] BY,
   output logic [NUM_AXES-1:0] AE,
   output logic [NUM_AXES-1:0] BE
);

   logic [ADDR_W:0]     addr_ext;
   logic [ADDR_W-3:0]   axis_sel;
   logic [31:0]         rd_words [NUM_AXES];
   logic [NUM_AXES-1:0] irq_vec;
   logic [31:0]         rd_sel;
   logic [31:0]         readdata_q, readdata_d;

   assign avs_ctrl_waitrequest = 1'b0;
   // Zero-extend so the axis field exists even for a single axis
   assign addr_ext = {1'b0, avs_ctrl_address};
   assign axis_sel = addr_ext[ADDR_W:3];

   for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
      step_motor_axis #(
         .PWM_W  (PWM_W),
         .RATE_W (RATE_W),
         .POS_W  (POS_W)
      ) u_axis (
         .clk       (csi_MCLK_clk),
         .rst_n     (rsi_MRST_reset_n),
         .wr_en     (avs_ctrl_write && (axis_sel == (ADDR_W-2)'(i))),
         .reg_addr  (avs_ctrl_address[2:0]),
         .wdata     (avs_ctrl_writedata),
         .byteen    (avs_ctrl_byteenable),
         .rd_word   (rd_words[i]),
         .irq       (irq_vec[i]),
         .coil_ax   (AX[i]),
         .coil_ay   (AY[i]),
         .coil_bx   (BX[i]),
         .coil_by   (BY[i]),
         .bridge_ae (AE[i]),
         .bridge_be (BE[i])
      );
   end

   // Read mux; axes beyond NUM_AXES read as zero
   always_comb begin
      rd_sel = 32'd0;
      for (int i = 0; i < NUM_AXES; i++)
         if (axis_sel == (ADDR_W-2)'(i)) rd_sel = rd_words[i];
      readdata_d = avs_ctrl_read ? rd_sel : readdata_q;
   end

   // One-cycle read latency; data held between reads
   always_ff @(posedge csi_MCLK_clk) begin
      if (!rsi_MRST_reset_n) readdata_q <= 32'd0;
      else                   readdata_q <= readdata_d;
   end

   assign avs_ctrl_readdata = readdata_q;
   assign ins_irq_irq       = |irq_vec;

endmodule

// File: tb/tb_step_motor_multi_axis.sv
// Directed bench for step_motor_multi_axis (2 axes): reset, byte lanes,
// full/half stepping timing, PWM duty, abort and interrupt handling.
module tb_step_motor_multi_axis;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  address;
   logic [31:0] writedata, readdata;
   logic [3:0]  byteenable;
   logic        write, read, waitrequest, irq;
   logic [1:0]  AX, AY, BX, BY, AE, BE;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   step_motor_multi_axis #(.NUM_AXES(2), .PWM_W(16), .RATE_W(24), .POS_W(32)) dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset_n     (rst_n),
      .avs_ctrl_address     (address),
      .avs_ctrl_writedata   (writedata),
      .avs_ctrl_readdata    (readdata),
      .avs_ctrl_byteenable  (byteenable),
      .avs_ctrl_write       (write),
      .avs_ctrl_read        (read),
      .avs_ctrl_waitrequest (waitrequest),
      .ins_irq_irq          (irq),
      .AX (AX), .AY (AY), .BX (BX), .BY (BY), .AE (AE), .BE (BE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int ax, input int r, input logic [31:0] d, input logic [3:0] be = 4'hF);
      @(negedge clk);
      address = 4'((ax << 3) | r); writedata = d; byteenable = be; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input int ax, input int r, output logic [31:0] d);
      @(negedge clk);
      address = 4'((ax << 3) | r); read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      d = readdata;
   endtask

   function automatic logic [31:0] coils(input int a);
      return {28'd0, AX[a], AY[a], BX[a], BY[a]};
   endfunction

   logic [31:0] d;
   int lows;

   initial begin
      rst_n = 1'b0; address = '0; writedata = '0; byteenable = 4'hF;
      write = 1'b0; read = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {20'd0, AX, AY, BX, BY, AE, BE}, 32'h0000_0FFF);
      chk("reset_readdata", readdata, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      rd(0, 7, d); chk("reset_status", d, 32'd0);
      rd(0, 6, d); chk("reset_position", d, 32'd0);

      // Byte-lane merge on the interval register
      wr(1, 3, 32'h0000_1234);
      wr(1, 3, 32'hFFFF_FF56, 4'b0001);
      rd(1, 3, d); chk("byteenable_merge", d, 32'h0000_1256);

      // Axis 0: full step forward, 3 steps, interval 4, 100% duty
      wr(0, 1, 10); wr(0, 2, 10); wr(0, 0, 10); wr(0, 3, 4); wr(0, 5, 32'h3);
      wr(0, 4, 3);                    // write at cycle N; now in N+1
      repeat (3) @(negedge clk); chk("ax0_n4_idx0", coils(0), 32'b0111);
      @(negedge clk);            chk("ax0_n5_idx2", coils(0), 32'b1101);
      repeat (4) @(negedge clk); chk("ax0_n9_idx4", coils(0), 32'b1011);
      repeat (4) @(negedge clk); chk("ax0_n13_idx6", coils(0), 32'b1110);
      chk("ax0_bridges", {30'd0, AE[0], BE[0]}, 32'd0);
      rd(0, 7, d); chk("ax0_status_done", d, 32'h2);
      rd(0, 6, d); chk("ax0_position", d, 32'd3);
      chk("ax0_irq_masked", {31'd0, irq}, 32'd0);

      // Axis 1: half step reverse, 2 steps, interval 2
      wr(1, 1, 5); wr(1, 2, 5); wr(1, 0, 5); wr(1, 3, 2); wr(1, 5, 32'h5);
      wr(1, 4, 2);
      repeat (2) @(negedge clk); chk("ax1_idx7", coils(1), 32'b0110);
      repeat (2) @(negedge clk); chk("ax1_idx6", coils(1), 32'b1110);
      rd(1, 6, d); chk("ax1_position", d, 32'hFFFF_FFFE);
      rd(1, 7, d); chk("ax1_status_done", d, 32'h2);
      chk("ax0_unchanged", coils(0), 32'b1110);

      // Axis 0: one more full step forward to index 0
      wr(0, 4, 1);
      repeat (6) @(negedge clk); chk("ax0_back_idx0", coils(0), 32'b0111);

      // PWM duty 3 of 8 on phase A while holding
      wr(0, 0, 8); wr(0, 1, 3);
      repeat (25) @(negedge clk);
      lows = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (!AX[0]) lows++; end
      chk("pwm_duty3_of8", 32'(lows), 32'd3);
      wr(0, 1, 0);
      repeat (25) @(negedge clk);
      lows = 0;
      for (int i = 0; i < 16; i++) begin @(negedge clk); if (!AX[0]) lows++; end
      chk("pwm_duty0_off", 32'(lows), 32'd0);

      // Abort a 100-step move after 5 steps (position 4 -> 9)
      wr(0, 4, 100);                  // cycle N; steps land at N+4k edges
      repeat (21) @(negedge clk);     // now in N+22
      wr(0, 7, 32'h1);                // abort captured at N+22
      rd(0, 7, d); chk("abort_status", d, 32'h0);
      rd(0, 6, d); chk("abort_position", d, 32'd9);
      repeat (10) @(negedge clk);
      rd(0, 6, d); chk("abort_position_held", d, 32'd9);
      chk("abort_irq", {31'd0, irq}, 32'd0);

      // Interrupt on completion, cleared by status write
      wr(1, 7, 32'h2); wr(1, 5, 32'hD);
      chk("irq_before_move", {31'd0, irq}, 32'd0);
      wr(1, 4, 1);
      repeat (3) @(negedge clk); chk("irq_on_done", {31'd0, irq}, 32'd1);
      rd(1, 7, d); chk("irq_status_done", d, 32'h2);
      wr(1, 7, 32'h2);
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
